// File: rtl/serial_bcd_addsub.sv
// rtl/serial_bcd_addsub.sv - digit-serial BCD adder/subtractor with framing and error detection
// Optional input digit validation: define BCD_DIGIT_CHECK_EN.
module serial_bcd_addsub #(
    parameter int DIGITS    = 1,
    parameter int MAX_BEATS = 8
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                in_valid,
    input  logic                in_first,
    input  logic                in_last,
    input  logic                sub,
    input  logic [4*DIGITS-1:0] a,
    input  logic [4*DIGITS-1:0] b,
    output logic                out_valid,
    output logic                out_first,
    output logic                out_last,
    output logic [4*DIGITS-1:0] sum,
    output logic                cout,
    output logic                err
);

    localparam int CW = $clog2(MAX_BEATS + 1);

`ifdef BCD_DIGIT_CHECK_EN
    localparam bit DIGIT_CHECK = 1'b1;
`else
    localparam bit DIGIT_CHECK = 1'b0;
`endif

    typedef enum logic {IDLE, RUN} state_t;

    state_t              state_q, state_d;
    logic                carry_q, carry_d;
    logic                sub_q, sub_d;
    logic [CW-1:0]       beat_cnt_q, beat_cnt_d;
    logic                out_valid_q, out_valid_d;
    logic                out_first_q, out_first_d;
    logic                out_last_q, out_last_d;
    logic [4*DIGITS-1:0] sum_q, sum_d;
    logic                cout_q, cout_d;
    logic                err_q, err_d;

    logic                mode;
    logic                c;
    logic [3:0]          a_dig, b_dig, s_dig;
    logic [4:0]          bb, t;
    logic [4*DIGITS-1:0] sum_raw;
    logic                carry_out;
    logic                digit_bad;
    logic                accept, force_last, last_eff, proto_err;

    // Digits ripple within the beat; subtraction is nines complement plus carry-in of one.
    always_comb begin
        mode      = in_first ? sub : sub_q;
        c         = in_first ? sub : carry_q;
        sum_raw   = '0;
        digit_bad = 1'b0;
        a_dig     = '0;
        b_dig     = '0;
        s_dig     = '0;
        bb        = '0;
        t         = '0;
        for (int i = 0; i < DIGITS; i++) begin
            a_dig = a[4*i +: 4];
            b_dig = b[4*i +: 4];
            bb    = mode ? (5'd9 - {1'b0, b_dig}) : {1'b0, b_dig};
            t     = {1'b0, a_dig} + bb + {4'd0, c};
            if (t > 5'd9) begin
                s_dig = t[3:0] + 4'd6;
                c     = 1'b1;
            end else begin
                s_dig = t[3:0];
                c     = 1'b0;
            end
            if (DIGIT_CHECK && (a_dig > 4'd9 || b_dig > 4'd9)) begin
                s_dig     = 4'hF;
                digit_bad = 1'b1;
            end
            sum_raw[4*i +: 4] = s_dig;
        end
        carry_out = c;
    end

    // Beats that arrive in IDLE without in_first are dropped.
    assign accept     = in_valid & ((state_q == RUN) | in_first);
    assign force_last = in_valid & (state_q == RUN) & ~in_first & ~in_last &
                        ((int'(beat_cnt_q) + 1) == MAX_BEATS);
    assign last_eff   = in_last | force_last;
    assign proto_err  = in_valid & (((state_q == IDLE) & ~in_first) |
                                    ((state_q == RUN) & in_first) | force_last);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (accept) begin
            if (in_first && !in_last) state_d = RUN;
            else if (last_eff)        state_d = IDLE;
        end
    end

    always_comb begin
        carry_d     = accept ? carry_out : carry_q;
        sub_d       = (accept && in_first) ? sub : sub_q;
        beat_cnt_d  = beat_cnt_q;
        if (accept && in_first) beat_cnt_d = CW'(1);
        else if (accept)        beat_cnt_d = beat_cnt_q + CW'(1);
        out_valid_d = accept;
        out_first_d = accept & in_first;
        out_last_d  = accept & last_eff;
        sum_d       = accept ? sum_raw : '0;
        cout_d      = accept & last_eff & carry_out;
        err_d       = proto_err | (accept & digit_bad);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            carry_q     <= 1'b0;
            sub_q       <= 1'b0;
            beat_cnt_q  <= '0;
            out_valid_q <= 1'b0;
            out_first_q <= 1'b0;
            out_last_q  <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            carry_q     <= carry_d;
            sub_q       <= sub_d;
            beat_cnt_q  <= beat_cnt_d;
            out_valid_q <= out_valid_d;
            out_first_q <= out_first_d;
            out_last_q  <= out_last_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            err_q       <= err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_first = out_first_q;
    assign out_last  = out_last_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign err       = err_q;

endmodule

// File: tb/tb_serial_bcd_addsub.sv
// tb/tb_serial_bcd_addsub.sv - self-checking bench for serial_bcd_addsub (DIGITS=1 and DIGITS=2)
module tb_serial_bcd_addsub;

    logic       clk = 1'b0;
    logic       rstn;
    logic       in_valid, in_first, in_last, sub;
    logic [3:0] a1, b1;
    logic [7:0] a2, b2;
    logic       ov1, of1, ol1, co1, er1;
    logic [3:0] s1;
    logic       ov2, of2, ol2, co2, er2;
    logic [7:0] s2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    serial_bcd_addsub #(.DIGITS(1), .MAX_BEATS(8)) dut1 (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_first(in_first), .in_last(in_last),
        .sub(sub), .a(a1), .b(b1), .out_valid(ov1), .out_first(of1), .out_last(ol1),
        .sum(s1), .cout(co1), .err(er1)
    );

    serial_bcd_addsub #(.DIGITS(2), .MAX_BEATS(8)) dut2 (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_first(in_first), .in_last(in_last),
        .sub(sub), .a(a2), .b(b2), .out_valid(ov2), .out_first(of2), .out_last(ol2),
        .sum(s2), .cout(co2), .err(er2)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h (v,f,l,c,e,sum)", tag, obs, exp);
        end
    endtask

    task automatic x1(input string tag, input bit v, f, l, c, e, input logic [3:0] s);
        chk(tag, {7'b0, ov1, of1, ol1, co1, er1, s1}, {7'b0, v, f, l, c, e, s});
    endtask

    task automatic x2(input string tag, input bit v, f, l, c, e, input logic [7:0] s);
        chk(tag, {3'b0, ov2, of2, ol2, co2, er2, s2}, {3'b0, v, f, l, c, e, s});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bt(input bit v, f, l, s, input logic [3:0] a, b);
        in_valid = v; in_first = f; in_last = l; sub = s;
        a1 = a; b1 = b; a2 = '0; b2 = '0;
        step();
    endtask

    task automatic bt2(input bit v, f, l, s, input logic [7:0] a, b);
        in_valid = v; in_first = f; in_last = l; sub = s;
        a1 = '0; b1 = '0; a2 = a; b2 = b;
        step();
    endtask

    function automatic longint unsigned pow10(input int n);
        longint unsigned p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    function automatic logic [3:0] dg(input longint unsigned v, input int j);
        return 4'((v / pow10(j)) % 10);
    endfunction

    int              n;
    bit              s_op;
    logic [3:0]      ad1[8], bd1[8];
    logic [3:0]      ad2[16], bd2[16];
    longint unsigned A1, B1, A2, B2, P1, P2, R1, R2;
    bit              C1, C2;

    initial begin
        rstn = 1'b0; in_valid = 0; in_first = 0; in_last = 0; sub = 0;
        a1 = 0; b1 = 0; a2 = 0; b2 = 0;
        repeat (2) @(posedge clk);
        #1;
        x1("reset1", 0, 0, 0, 0, 0, 4'h0);
        x2("reset2", 0, 0, 0, 0, 0, 8'h00);
        rstn = 1'b1;

        bt(1, 1, 1, 0, 4'd3, 4'd5);  x1("single_3p5", 1, 1, 1, 0, 0, 4'd8);
        bt(0, 0, 0, 0, 4'd0, 4'd0);  x1("idle_after", 0, 0, 0, 0, 0, 4'd0);

        bt(1, 1, 0, 0, 4'd3, 4'd0);  x1("add123_b0", 1, 1, 0, 0, 0, 4'd3);
        bt(1, 0, 0, 0, 4'd2, 4'd8);  x1("add123_b1", 1, 0, 0, 0, 0, 4'd0);
        bt(1, 0, 1, 0, 4'd1, 4'd4);  x1("add123_b2", 1, 0, 1, 0, 0, 4'd6);

        bt(1, 1, 0, 0, 4'd3, 4'd0);  x1("gap_b0", 1, 1, 0, 0, 0, 4'd3);
        bt(1, 0, 0, 0, 4'd2, 4'd8);  x1("gap_b1", 1, 0, 0, 0, 0, 4'd0);
        bt(0, 0, 0, 0, 4'd7, 4'd7);  x1("gap_idle", 0, 0, 0, 0, 0, 4'd0);
        bt(1, 0, 1, 0, 4'd1, 4'd4);  x1("gap_b2", 1, 0, 1, 0, 0, 4'd6);

        bt(1, 1, 0, 1, 4'd5, 4'd3);  x1("sub405_b0", 1, 1, 0, 0, 0, 4'd2);
        bt(1, 0, 0, 0, 4'd0, 4'd2);  x1("sub405_b1", 1, 0, 0, 0, 0, 4'd8);
        bt(1, 0, 1, 0, 4'd4, 4'd1);  x1("sub405_b2", 1, 0, 1, 1, 0, 4'd2);

        bt(1, 1, 0, 1, 4'd3, 4'd0);  x1("sub123_b0", 1, 1, 0, 0, 0, 4'd3);
        bt(1, 0, 0, 0, 4'd2, 4'd8);  x1("sub123_b1", 1, 0, 0, 0, 0, 4'd4);
        bt(1, 0, 1, 0, 4'd1, 4'd4);  x1("sub123_b2", 1, 0, 1, 0, 0, 4'd6);

        bt(1, 1, 0, 0, 4'd9, 4'd1);  x1("add999_b0", 1, 1, 0, 0, 0, 4'd0);
        bt(1, 0, 0, 0, 4'd9, 4'd0);  x1("add999_b1", 1, 0, 0, 0, 0, 4'd0);
        bt(1, 0, 1, 0, 4'd9, 4'd0);  x1("add999_b2", 1, 0, 1, 1, 0, 4'd0);

        bt2(1, 1, 0, 0, 8'h76, 8'h24); x2("d2_9876_b0", 1, 1, 0, 0, 0, 8'h00);
        bt2(1, 0, 1, 0, 8'h98, 8'h01); x2("d2_9876_b1", 1, 0, 1, 1, 0, 8'h00);

        bt(1, 0, 0, 0, 4'd1, 4'd1);  x1("idle_nonfirst", 0, 0, 0, 0, 1, 4'd0);

        bt(1, 1, 0, 0, 4'd3, 4'd0);  x1("restart_b0", 1, 1, 0, 0, 0, 4'd3);
        bt(1, 0, 0, 0, 4'd2, 4'd8);  x1("restart_b1", 1, 0, 0, 0, 0, 4'd0);
        bt(1, 1, 0, 0, 4'd4, 4'd5);  x1("restart_new", 1, 1, 0, 0, 1, 4'd9);
        bt(1, 0, 1, 0, 4'd1, 4'd1);  x1("restart_end", 1, 0, 1, 0, 0, 4'd2);

        for (int k = 0; k < 8; k++) begin
            bt(1, k == 0, 0, 0, 4'd9, (k == 0) ? 4'd1 : 4'd0);
            if (k < 7) x1($sformatf("maxb_%0d", k), 1, k == 0, 0, 0, 0, 4'd0);
            else       x1("maxb_forced", 1, 0, 1, 1, 1, 4'd0);
        end
        bt(1, 0, 0, 0, 4'd9, 4'd0);  x1("maxb_after", 0, 0, 0, 0, 1, 4'd0);

        bt(1, 1, 0, 0, 4'd3, 4'd0);
        bt(1, 0, 0, 0, 4'd2, 4'd8);  x1("pre_reset", 1, 0, 0, 0, 0, 4'd0);
        rstn = 1'b0;
        #1;
        x1("async_reset", 0, 0, 0, 0, 0, 4'd0);
        #2;
        rstn = 1'b1;
        bt(1, 1, 0, 0, 4'd4, 4'd5);  x1("post_rst_b0", 1, 1, 0, 0, 0, 4'd9);
        bt(1, 0, 1, 0, 4'd1, 4'd1);  x1("post_rst_b1", 1, 0, 1, 0, 0, 4'd2);

        bt(1, 1, 1, 0, 4'hA, 4'd0);
`ifdef BCD_DIGIT_CHECK_EN
        x1("digit_check", 1, 1, 1, 1, 1, 4'hF);
`else
        x1("digit_nocheck", 1, 1, 1, 1, 0, 4'd0);
`endif

        for (int op = 0; op < 30; op++) begin
            n    = $urandom_range(1, 8);
            s_op = 1'($urandom_range(0, 1));
            P1 = pow10(n); P2 = pow10(2 * n);
            A1 = 0; B1 = 0; A2 = 0; B2 = 0;
            for (int j = 0; j < n; j++) begin
                ad1[j] = 4'($urandom_range(0, 9)); bd1[j] = 4'($urandom_range(0, 9));
                A1 += longint'(ad1[j]) * pow10(j); B1 += longint'(bd1[j]) * pow10(j);
            end
            for (int j = 0; j < 2 * n; j++) begin
                ad2[j] = 4'($urandom_range(0, 9)); bd2[j] = 4'($urandom_range(0, 9));
                A2 += longint'(ad2[j]) * pow10(j); B2 += longint'(bd2[j]) * pow10(j);
            end
            if (s_op) begin
                C1 = (A1 >= B1); R1 = (A1 + P1 - B1) % P1;
                C2 = (A2 >= B2); R2 = (A2 + P2 - B2) % P2;
            end else begin
                C1 = (A1 + B1 >= P1); R1 = (A1 + B1) % P1;
                C2 = (A2 + B2 >= P2); R2 = (A2 + B2) % P2;
            end
            for (int k = 0; k < n; k++) begin
                if ($urandom_range(0, 3) == 0) begin
                    bt(0, 0, 0, 0, 4'd0, 4'd0);
                    x1("rnd_gap1", 0, 0, 0, 0, 0, 4'd0);
                    x2("rnd_gap2", 0, 0, 0, 0, 0, 8'h00);
                end
                in_valid = 1'b1;
                in_first = (k == 0);
                in_last  = (k == n - 1);
                sub      = (k == 0) ? s_op : 1'($urandom_range(0, 1));
                a1 = ad1[k]; b1 = bd1[k];
                a2 = {ad2[2*k+1], ad2[2*k]}; b2 = {bd2[2*k+1], bd2[2*k]};
                step();
                x1($sformatf("rnd1_op%0d_b%0d", op, k), 1, k == 0, k == n - 1,
                   (k == n - 1) && C1, 0, dg(R1, k));
                x2($sformatf("rnd2_op%0d_b%0d", op, k), 1, k == 0, k == n - 1,
                   (k == n - 1) && C2, 0, {dg(R2, 2 * k + 1), dg(R2, 2 * k)});
            end
        end
        bt(0, 0, 0, 0, 4'd0, 4'd0);
        x1("final_idle", 0, 0, 0, 0, 0, 4'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
